// File: rtl/store_buffer_if.sv
// CPU-side and memory-side signals of the posted store buffer.
// The slave modport is the buffer itself; master is the pipeline/memory environment.
interface store_buffer_if #(
    parameter int CW = 3
);
    logic          MemWrite_i;
    logic          MemRead_i;
    logic [31:0]   Addr_i;
    logic [31:0]   WriteData_i;
    logic [31:0]   ReadData_o;
    logic          stall_o;
    logic          mem_MemWrite_o;
    logic          mem_MemRead_o;
    logic [31:0]   mem_Addr_o;
    logic [31:0]   mem_WriteData_o;
    logic [31:0]   mem_ReadData_i;
    logic [CW-1:0] count_o;
    logic          empty_o;

    modport slave (
        input  MemWrite_i, MemRead_i, Addr_i, WriteData_i, mem_ReadData_i,
        output ReadData_o, stall_o, mem_MemWrite_o, mem_MemRead_o,
               mem_Addr_o, mem_WriteData_o, count_o, empty_o
    );

    modport master (
        output MemWrite_i, MemRead_i, Addr_i, WriteData_i, mem_ReadData_i,
        input  ReadData_o, stall_o, mem_MemWrite_o, mem_MemRead_o,
               mem_Addr_o, mem_WriteData_o, count_o, empty_o
    );
endinterface

// File: rtl/store_buffer.sv
// Posted store buffer: FIFO of stores retired to single-port memory in free cycles,
// with youngest-match load forwarding at word granularity.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic           clk_i,
    input  logic           rst_i,
    store_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic          full;
    logic          empty;
    logic          store_acc;
    logic          match;
    logic [31:0]   fwd_data;
    logic          hit;
    logic          load_miss;
    logic          drain;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign store_acc = bus.MemWrite_i & ~full;

    // Walk oldest to youngest so the last match, nearest the tail, wins.
    always_comb begin
        match    = 1'b0;
        fwd_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) &&
                (addr_q[head_q + PW'(k)][31:2] == bus.Addr_i[31:2])) begin
                match    = 1'b1;
                fwd_data = data_q[head_q + PW'(k)];
            end
        end
    end

    assign hit       = bus.MemRead_i & match;
    assign load_miss = bus.MemRead_i & ~bus.MemWrite_i & ~hit;
    assign drain     = ~empty & ~load_miss & ~store_acc;

    always_comb begin
        bus.stall_o         = bus.MemWrite_i & full;
        bus.mem_MemWrite_o  = drain;
        bus.mem_MemRead_o   = load_miss;
        bus.mem_Addr_o      = empty ? '0 : addr_q[head_q];
        bus.mem_WriteData_o = empty ? '0 : data_q[head_q];
        if (load_miss) begin
            bus.mem_Addr_o = bus.Addr_i;
        end
        bus.ReadData_o      = hit ? fwd_data : bus.mem_ReadData_i;
        bus.count_o         = count_q;
        bus.empty_o         = empty;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (store_acc) begin
            tail_q  <= tail_q + PW'(1);
            count_q <= count_q + CW'(1);
        end else if (drain) begin
            head_q  <= head_q + PW'(1);
            count_q <= count_q - CW'(1);
        end
    end

    // Entry contents need no reset: validity comes from head/count alone.
    always_ff @(posedge clk_i) begin
        if (store_acc) begin
            addr_q[tail_q] <= bus.Addr_i;
            data_q[tail_q] <= bus.WriteData_i;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: per-scenario tasks plus a scoreboard
// of expected memory writes popped whenever the buffer retires a store.
module tb_store_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    store_buffer_if #(.CW(3)) bus ();

    store_buffer #(.DEPTH(4), .CW(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Fake memory: read data is a fixed function of the address.
    assign bus.mem_ReadData_i = ~bus.mem_Addr_o;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    always @(negedge clk) begin
        if (!rst && bus.mem_MemWrite_o === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write: got addr=%h data=%h, expected no write",
                         bus.mem_Addr_o, bus.mem_WriteData_o);
            end else begin
                mon_e = sb.pop_front();
                if (bus.mem_Addr_o !== mon_e.a || bus.mem_WriteData_o !== mon_e.d) begin
                    n_fail++;
                    $display("FAIL sb_write_order: got addr=%h data=%h, expected addr=%h data=%h",
                             bus.mem_Addr_o, bus.mem_WriteData_o, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite_i  = w;
        bus.MemRead_i   = r;
        bus.Addr_i      = a;
        bus.WriteData_i = d;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic drain_all(input string tag);
        drv(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (bus.empty_o === 1'b1) break;
        end
        n_checks++;
        if (bus.empty_o !== 1'b1 || bus.count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_drain_empty: got empty=%b count=%0d, expected empty=1 count=0",
                     tag, bus.empty_o, bus.count_o);
        end
    endtask

    task automatic test_reset();
        drv(1'b1, 1'b0, 32'h0, 32'h0);
        #2;
        n_checks++;
        if (bus.count_o !== 3'd0 || bus.empty_o !== 1'b1 || bus.stall_o !== 1'b0 ||
            bus.mem_MemWrite_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got count=%0d empty=%b stall=%b mwr=%b, expected 0 1 0 0",
                     bus.count_o, bus.empty_o, bus.stall_o, bus.mem_MemWrite_o);
        end
        drv(1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        cyc(); drv(1'b1, 1'b0, 32'h40, 32'h4040); push(32'h40, 32'h4040);
        cyc(); drv(1'b1, 1'b0, 32'h44, 32'h4444); push(32'h44, 32'h4444);
        cyc();
        n_checks++;
        if (bus.count_o !== 3'd2) begin
            n_fail++;
            $display("FAIL rstmid_count_before: got %0d, expected 2", bus.count_o);
        end
        rst = 1'b1;
        drv(1'b0, 1'b0, '0, '0);
        sb.delete();
        #1;
        n_checks++;
        if (bus.count_o !== 3'd0 || bus.empty_o !== 1'b1 || bus.mem_MemWrite_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got count=%0d empty=%b mwr=%b, expected 0 1 0",
                     bus.count_o, bus.empty_o, bus.mem_MemWrite_o);
        end
        cyc(); rst = 1'b0;
        drv(1'b0, 1'b1, 32'h0, '0);
        @(negedge clk);
        n_checks++;
        if (bus.mem_MemRead_o !== 1'b1 || bus.ReadData_o !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL rstmid_load: got mrd=%b rdata=%h, expected 1 ffffffff",
                     bus.mem_MemRead_o, bus.ReadData_o);
        end
    endtask

    task automatic test_single_retire();
        cyc(); drv(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF); push(32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        n_checks++;
        if (bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_stall: got %b, expected 0", bus.stall_o);
        end
        cyc(); drv(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        n_checks++;
        if (bus.mem_MemWrite_o !== 1'b1 || bus.mem_Addr_o !== 32'h10 ||
            bus.mem_WriteData_o !== 32'hDEAD_BEEF || bus.count_o !== 3'd1) begin
            n_fail++;
            $display("FAIL single_retire: got mwr=%b addr=%h data=%h count=%0d, expected 1 10 deadbeef 1",
                     bus.mem_MemWrite_o, bus.mem_Addr_o, bus.mem_WriteData_o, bus.count_o);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (bus.empty_o !== 1'b1 || bus.mem_MemWrite_o !== 1'b0 || bus.mem_Addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL single_empty: got empty=%b mwr=%b addr=%h, expected 1 0 0",
                     bus.empty_o, bus.mem_MemWrite_o, bus.mem_Addr_o);
        end
    endtask

    task automatic test_back_to_back_full();
        for (int i = 0; i < 4; i++) begin
            cyc(); drv(1'b1, 1'b0, 32'(4 * i), 32'h1000 + 32'(i));
            push(32'(4 * i), 32'h1000 + 32'(i));
        end
        cyc(); drv(1'b1, 1'b0, 32'h10, 32'h2000);
        @(negedge clk);
        n_checks++;
        if (bus.count_o !== 3'd4 || bus.stall_o !== 1'b1 || bus.mem_MemWrite_o !== 1'b1 ||
            bus.mem_Addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL full_stall: got count=%0d stall=%b mwr=%b addr=%h, expected 4 1 1 0",
                     bus.count_o, bus.stall_o, bus.mem_MemWrite_o, bus.mem_Addr_o);
        end
        cyc(); push(32'h10, 32'h2000);
        @(negedge clk);
        n_checks++;
        if (bus.stall_o !== 1'b0 || bus.count_o !== 3'd3) begin
            n_fail++;
            $display("FAIL full_accept: got stall=%b count=%0d, expected 0 3",
                     bus.stall_o, bus.count_o);
        end
        cyc(); drv(1'b0, 1'b0, '0, '0);
        n_checks++;
        if (bus.count_o !== 3'd4) begin
            n_fail++;
            $display("FAIL full_refill: got count=%0d, expected 4", bus.count_o);
        end
        drain_all("full");
    endtask

    task automatic test_forward();
        cyc(); drv(1'b1, 1'b0, 32'h8, 32'h11); push(32'h8, 32'h11);
        cyc(); drv(1'b1, 1'b0, 32'h9, 32'h22); push(32'h9, 32'h22);
        cyc(); drv(1'b0, 1'b1, 32'hA, '0);
        @(negedge clk);
        n_checks++;
        if (bus.ReadData_o !== 32'h22 || bus.mem_MemRead_o !== 1'b0 || bus.mem_MemWrite_o !== 1'b1 ||
            bus.mem_Addr_o !== 32'h8 || bus.mem_WriteData_o !== 32'h11) begin
            n_fail++;
            $display("FAIL fwd_youngest: got rdata=%h mrd=%b mwr=%b addr=%h data=%h, expected 22 0 1 8 11",
                     bus.ReadData_o, bus.mem_MemRead_o, bus.mem_MemWrite_o, bus.mem_Addr_o, bus.mem_WriteData_o);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (bus.ReadData_o !== 32'h22 || bus.mem_MemRead_o !== 1'b0 || bus.mem_Addr_o !== 32'h9) begin
            n_fail++;
            $display("FAIL fwd_last_entry: got rdata=%h mrd=%b addr=%h, expected 22 0 9",
                     bus.ReadData_o, bus.mem_MemRead_o, bus.mem_Addr_o);
        end
        drain_all("fwd");
    endtask

    task automatic test_load_miss();
        cyc(); drv(1'b1, 1'b0, 32'h0, 32'h5); push(32'h0, 32'h5);
        cyc(); drv(1'b0, 1'b1, 32'h4, '0);
        @(negedge clk);
        n_checks++;
        if (bus.mem_MemRead_o !== 1'b1 || bus.mem_Addr_o !== 32'h4 || bus.mem_MemWrite_o !== 1'b0 ||
            bus.ReadData_o !== ~32'h4 || bus.count_o !== 3'd1) begin
            n_fail++;
            $display("FAIL miss_path: got mrd=%b addr=%h mwr=%b rdata=%h count=%0d, expected 1 4 0 fffffffb 1",
                     bus.mem_MemRead_o, bus.mem_Addr_o, bus.mem_MemWrite_o, bus.ReadData_o, bus.count_o);
        end
        cyc(); drv(1'b0, 1'b0, '0, '0);
        n_checks++;
        if (bus.count_o !== 3'd1) begin
            n_fail++;
            $display("FAIL miss_count_held: got %0d, expected 1", bus.count_o);
        end
        @(negedge clk);
        n_checks++;
        if (bus.mem_MemWrite_o !== 1'b1 || bus.mem_Addr_o !== 32'h0 || bus.mem_WriteData_o !== 32'h5) begin
            n_fail++;
            $display("FAIL miss_then_drain: got mwr=%b addr=%h data=%h, expected 1 0 5",
                     bus.mem_MemWrite_o, bus.mem_Addr_o, bus.mem_WriteData_o);
        end
        drain_all("miss");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            cyc(); drv(1'b1, 1'b0, 32'(4 * i), 32'hA000_0000 | 32'(i));
            push(32'(4 * i), 32'hA000_0000 | 32'(i));
            @(negedge clk);
            n_checks++;
            if (bus.stall_o !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_stall_%0d: got %b, expected 0", i, bus.stall_o);
            end
            if (i % 2 == 1) begin
                cyc(); drv(1'b0, 1'b0, '0, '0);
                if (i % 4 == 3) cyc();
            end
        end
        drain_all("wrap");
    endtask

    initial begin
        drv(1'b0, 1'b0, '0, '0);
        test_reset();
        test_reset_mid();
        test_single_retire();
        test_back_to_back_full();
        test_forward();
        test_load_miss();
        test_wrap();
        cyc();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending writes, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
